// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU opcodes,
// compare-flag encodings and branch condition codes.
package cpu_defs;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NAND = 4'h5;
  localparam logic [3:0] ALU_NOR  = 4'h6;
  localparam logic [3:0] ALU_XNOR = 4'h7;

  localparam logic [1:0] CMD_EQ = 2'b00;
  localparam logic [1:0] CMD_LT = 2'b01;
  localparam logic [1:0] CMD_GT = 2'b10;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_LE     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_NE     = 3'd6;
  localparam logic [2:0] COND_ALWAYS = 3'd7;

endpackage

// File: rtl/operand_regfile_if.sv
// Operand register file bus: read ports,
// writeback port, flag capture and branch query.
interface operand_regfile_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              flag_we;
  logic [1:0]        cmdflag_in;
  logic [2:0]        cond;
  logic [1:0]        flags;
  logic              taken;

  modport master (
    output rs_addr, rt_addr,
    output wr_en, wr_addr, wr_data,
    output flag_we, cmdflag_in, cond,
    input  rs_data, rt_data,
    input  flags, taken
  );

  modport slave (
    input  rs_addr, rt_addr,
    input  wr_en, wr_addr, wr_data,
    input  flag_we, cmdflag_in, cond,
    output rs_data, rt_data,
    output flags, taken
  );

endinterface

// File: rtl/operand_regfile_cond_eval.sv
// Branch condition evaluator: maps latched
// compare flag and condition select to taken.
module cond_eval
  import cpu_defs::*;
(
  input  logic [1:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  logic w_eq;
  logic w_lt;
  logic w_gt;

  assign w_eq = (i_flags == CMD_EQ);
  assign w_lt = (i_flags == CMD_LT);
  assign w_gt = (i_flags == CMD_GT);

  // decode condition select into taken
  always_comb begin
    o_taken = 1'b0;
    unique case (i_cond)
      COND_NEVER:  o_taken = 1'b0;
      COND_EQ:     o_taken = w_eq;
      COND_LT:     o_taken = w_lt;
      COND_GT:     o_taken = w_gt;
      COND_LE:     o_taken = w_eq | w_lt;
      COND_GE:     o_taken = w_eq | w_gt;
      COND_NE:     o_taken = ~w_eq;
      COND_ALWAYS: o_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/operand_regfile.sv
// Register file and compare-flag register
// feeding the ALU operands and branch logic.
module operand_regfile
  import cpu_defs::*;
#(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  operand_regfile_if.slave  bus
);

  localparam bit P_ZERO = (ZERO_REG != 0);
  localparam bit P_BYP  = (BYPASS != 0);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [1:0]       r_flags;

  logic w_wr_ok;
  logic w_rs_zero;
  logic w_rt_zero;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_flag_ok;

  // r0 writes vanish when it is hardwired
  assign w_wr_ok = bus.wr_en &&
    !(P_ZERO && (bus.wr_addr == '0));

  assign w_rs_zero = P_ZERO &&
    (bus.rs_addr == '0);
  assign w_rt_zero = P_ZERO &&
    (bus.rt_addr == '0);

  assign w_rs_hit = P_BYP && w_wr_ok &&
    (bus.wr_addr == bus.rs_addr);
  assign w_rt_hit = P_BYP && w_wr_ok &&
    (bus.wr_addr == bus.rt_addr);

  assign bus.rs_data =
    w_rs_zero ? '0 :
    w_rs_hit  ? bus.wr_data :
                r_regs[bus.rs_addr];

  assign bus.rt_data =
    w_rt_zero ? '0 :
    w_rt_hit  ? bus.wr_data :
                r_regs[bus.rt_addr];

  assign bus.flags = r_flags;

  // only real compare codes may be latched
  always_comb begin
    w_flag_ok = 1'b0;
    case (bus.cmdflag_in)
      CMD_EQ, CMD_LT, CMD_GT: w_flag_ok = 1'b1;
      default:                w_flag_ok = 1'b0;
    endcase
  end

  // register array writeback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // compare flag capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= CMD_EQ;
    end else if (bus.flag_we && w_flag_ok) begin
      r_flags <= bus.cmdflag_in;
    end
  end

  cond_eval u_cond (
    .i_flags (r_flags),
    .i_cond  (bus.cond),
    .o_taken (bus.taken)
  );

endmodule

// File: tb/tb_operand_regfile.sv
// Scoreboard bench for operand_regfile with
// a behavioural register/flag reference model.
module tb_operand_regfile;

  typedef struct {
    logic [7:0] rs;
    logic [7:0] rt;
    logic [1:0] fl;
    logic       tk;
    string      tag;
  } exp_t;

  logic clk;
  logic reset_n;

  operand_regfile_if #(
    .WIDTH  (8),
    .ADDR_W (4)
  ) bus ();

  operand_regfile #(
    .WIDTH    (8),
    .NREGS    (16),
    .ADDR_W   (4),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // which flag codes (bit0 EQ, bit1 LT,
  // bit2 GT) make each condition true
  logic [2:0] take_mask [8];

  int   m_reg [16];
  int   m_flags;
  exp_t sb [$];
  bit   chk_valid;
  int   n_pass;
  int   n_tot;
  exp_t mon_e;

  function automatic int m_read(
    input int a, input bit we,
    input int wa, input int wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd & 255;
    return m_reg[a];
  endfunction

  function automatic void check(
    input string name, input string fld,
    input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display(
      "FAIL %s.%s: got %0h, expected %0h",
      name, fld, act, exp);
  endfunction

  task automatic step(
    input bit rn,
    input int rs, input int rt,
    input bit we, input int wa,
    input int wd,
    input bit fwe, input int cf,
    input int cnd, input string tag);
    exp_t e;
    logic [2:0] msk;
    @(posedge clk);
    #1;
    reset_n        = rn;
    bus.rs_addr    = 4'(rs);
    bus.rt_addr    = 4'(rt);
    bus.wr_en      = we;
    bus.wr_addr    = 4'(wa);
    bus.wr_data    = 8'(wd);
    bus.flag_we    = fwe;
    bus.cmdflag_in = 2'(cf);
    bus.cond       = 3'(cnd);
    if (!rn) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_flags = 0;
    end
    msk    = take_mask[cnd];
    e.rs   = 8'(m_read(rs, we, wa, wd));
    e.rt   = 8'(m_read(rt, we, wa, wd));
    e.fl   = 2'(m_flags);
    e.tk   = msk[m_flags];
    e.tag  = tag;
    sb.push_back(e);
    chk_valid = 1'b1;
    if (rn) begin
      if (we && wa != 0) m_reg[wa] = wd & 255;
      if (fwe && cf != 3) m_flags = cf;
    end
  endtask

  // monitor: one expectation per cycle
  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL sb_underflow: got 0, expected 1");
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.tag, "rs",
          int'(bus.rs_data), int'(mon_e.rs));
        check(mon_e.tag, "rt",
          int'(bus.rt_data), int'(mon_e.rt));
        check(mon_e.tag, "flags",
          int'(bus.flags), int'(mon_e.fl));
        check(mon_e.tag, "taken",
          int'(bus.taken), int'(mon_e.tk));
      end
    end
  end

  initial begin
    int a;
    int b;
    int f;
    take_mask = '{3'b000, 3'b001, 3'b010,
                  3'b100, 3'b011, 3'b101,
                  3'b110, 3'b111};
    clk = 1'b0;
    reset_n = 1'b0;
    bus.rs_addr = '0;
    bus.rt_addr = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.flag_we = 1'b0;
    bus.cmdflag_in = '0;
    bus.cond = '0;
    foreach (m_reg[i]) m_reg[i] = 0;
    m_flags = 0;
    chk_valid = 1'b0;
    n_pass = 0;
    n_tot = 0;
    repeat (2) @(posedge clk);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_hold");
    for (int i = 0; i < 16; i++)
      step(1, i, 15 - i, 0, 0, 0, 0, 0, 0,
           "rst_read");

    step(1, 0, 0, 1, 3, 'h5A, 0, 0, 0, "wr_r3");
    step(1, 3, 3, 0, 0, 0, 0, 0, 0, "rd_r3");
    step(1, 0, 0, 1, 0, 'hFF, 0, 0, 0, "wr_r0");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rd_r0");

    step(1, 0, 0, 1, 7, 'h11, 0, 0, 0, "wr_r7");
    step(1, 7, 7, 1, 7, 'h3C, 0, 0, 0, "bypass");
    step(1, 7, 7, 0, 0, 0, 0, 0, 0, "rd_r7");

    step(1, 0, 0, 0, 0, 0, 1, 1, 0, "cap_lt");
    for (int c = 0; c < 8; c++)
      step(1, 0, 0, 0, 0, 0, 0, 0, c, "cond_sweep");
    step(1, 0, 0, 0, 0, 0, 1, 3, 2, "cap_11");
    step(1, 0, 0, 0, 0, 0, 0, 0, 2, "flag_hold");

    step(1, 0, 0, 1, 1, 'h80, 0, 0, 0, "wr_r1");
    step(1, 0, 0, 1, 2, 'h7F, 0, 0, 0, "wr_r2");
    a = m_read(1, 0, 0, 0);
    b = m_read(2, 0, 0, 0);
    f = (a == b) ? 0 : (a < b) ? 1 : 2;
    step(1, 1, 2, 0, 0, 0, 1, f, 3, "alu_cap");
    step(1, 1, 2, 0, 0, 0, 0, 0, 3, "alu_gt");
    step(1, 1, 2, 0, 0, 0, 0, 0, 4, "alu_le");

    step(1, 0, 0, 1, 5, 'h99, 0, 0, 0, "wr_r5");
    step(0, 5, 3, 0, 0, 0, 0, 0, 7, "mid_rst");
    step(0, 3, 1, 1, 6, 'h77, 1, 2, 0, "rst_wr");
    step(1, 6, 5, 0, 0, 0, 0, 0, 0, "rst_lost");

    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 63) != 0),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)),
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)),
           "random");

    @(negedge clk);
    #1;
    chk_valid = 1'b0;
    n_tot++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d, expected 0",
                  sb.size());
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
